wb_commit_unit: RTL

- Parametrised writeback/commit stage for the 5-stage LoongArch pipeline; successor to the fixed-width WB stage.
- Latches the MEM->WB payload, writes the register file and CSRs, and raises exceptions/ertn to the CSR file.
- Replaces the sticky exc/ertn kill registers with an epoch tag, so wrong-path instructions are dropped exactly, not until the next accept.
- Adds a prioritised exception encoder, CSR-busy stall and an optional retired-instruction counter.

---
 rtl/wb_commit_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: latches the MEM->WB payload and retires it to the GPR/CSR files,
// dropping wrong-path instructions by epoch. Optional macro WB_INSTRET_EN adds a 64-bit retired counter.
module wb_commit_unit #(
    parameter int         XLEN           = 32,
    parameter int         EX_W           = 6,
    parameter logic [5:0] EXT_ECODE_BASE = 6'h10
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_allow_in,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    input  logic            in_gr_we,
    input  logic [4:0]      in_dest,
    input  logic [XLEN-1:0] in_result,
    input  logic [EX_W-1:0] in_ex_type,
    input  logic            in_ertn,
    input  logic            in_csr_we,
    input  logic [13:0]     in_csr_num,
    input  logic [XLEN-1:0] in_csr_wmask,
    input  logic [XLEN-1:0] in_csr_wvalue,
    input  logic            in_epoch,
    input  logic            csr_busy,
    output logic            cur_epoch,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            csr_we,
    output logic [13:0]     csr_num,
    output logic [XLEN-1:0] csr_wmask,
    output logic [XLEN-1:0] csr_wvalue,
    output logic            wb_ex,
    output logic [5:0]      wb_ecode,
    output logic [8:0]      wb_esubcode,
    output logic [XLEN-1:0] wb_pc,
    output logic [XLEN-1:0] wb_badvaddr,
    output logic            ertn_flush,
    output logic [XLEN-1:0] debug_wb_pc,
    output logic [3:0]      debug_wb_rf_we,
    output logic [4:0]      debug_wb_rf_wnum,
    output logic [XLEN-1:0] debug_wb_rf_wdata
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]     instret
`endif
);

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    logic            wb_valid;
    logic            stamp;
    logic            epoch_q;
    logic [XLEN-1:0] pc_q;
    logic            gr_we_q;
    logic [4:0]      dest_q;
    logic [XLEN-1:0] result_q;
    logic [EX_W-1:0] ex_q;
    logic            ertn_q;
    logic            csr_we_q;
    logic [13:0]     csr_num_q;
    logic [XLEN-1:0] csr_wmask_q;
    logic [XLEN-1:0] csr_wvalue_q;

    logic live, ex_any, ready_go, commit;
    logic [5:0] ecode;

    // The instruction word is carried for tracing upstream only; nothing here decodes it.
    logic unused_inst;
    assign unused_inst = ^in_inst;

    // Handshake: a payload transfers on any edge where in_valid & in_allow_in; WB holds its
    // payload only while a live, non-excepting CSR write waits on csr_busy. Stale-epoch
    // instructions never stall, so they drain without a strobe.
    assign live        = wb_valid & (stamp == epoch_q);
    assign ex_any      = |ex_q;
    assign ready_go    = ~(live & csr_we_q & csr_busy & ~ex_any);
    assign in_allow_in = ~wb_valid | ready_go;
    assign commit      = live & ready_go;

    assign wb_ex       = commit & ex_any;
    assign ertn_flush  = commit & ertn_q & ~ex_any;
    assign rf_we       = commit & gr_we_q & ~ex_any & ~ertn_q;
    assign csr_we      = commit & csr_we_q & ~ex_any;

    // Assignments run lowest to highest priority so the last match wins.
    always_comb begin
        ecode = 6'h00;
        for (int k = EX_W - 1; k >= 6; k--) begin
            if (ex_q[k]) ecode = EXT_ECODE_BASE + 6'(k - 6);
        end
        if (ex_q[2]) ecode = ECODE_ALE;
        if (ex_q[3]) ecode = ECODE_BRK;
        if (ex_q[0]) ecode = ECODE_SYS;
        if (ex_q[4]) ecode = ECODE_INE;
        if (ex_q[1]) ecode = ECODE_ADEF;
        if (ex_q[5]) ecode = ECODE_INT;
    end

    assign wb_ecode    = ecode;
    assign wb_esubcode = 9'h000;
    assign wb_pc       = pc_q;
    assign wb_badvaddr = (ex_q[1] & ~ex_q[5]) ? pc_q : result_q;
    assign cur_epoch   = epoch_q;

    assign rf_waddr    = dest_q;
    assign rf_wdata    = result_q;
    assign csr_num     = csr_num_q;
    assign csr_wmask   = csr_wmask_q;
    assign csr_wvalue  = csr_wvalue_q;

    assign debug_wb_pc       = pc_q;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = dest_q;
    assign debug_wb_rf_wdata = result_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_valid     <= 1'b0;
            stamp        <= 1'b0;
            epoch_q      <= 1'b0;
            pc_q         <= '0;
            gr_we_q      <= 1'b0;
            dest_q       <= '0;
            result_q     <= '0;
            ex_q         <= '0;
            ertn_q       <= 1'b0;
            csr_we_q     <= 1'b0;
            csr_num_q    <= '0;
            csr_wmask_q  <= '0;
            csr_wvalue_q <= '0;
        end else begin
            if (wb_ex | ertn_flush) epoch_q <= ~epoch_q;
            if (in_allow_in) wb_valid <= in_valid;
            if (in_valid & in_allow_in) begin
                stamp        <= in_epoch;
                pc_q         <= in_pc;
                gr_we_q      <= in_gr_we;
                dest_q       <= in_dest;
                result_q     <= in_result;
                ex_q         <= in_ex_type;
                ertn_q       <= in_ertn;
                csr_we_q     <= in_csr_we;
                csr_num_q    <= in_csr_num;
                csr_wmask_q  <= in_csr_wmask;
                csr_wvalue_q <= in_csr_wvalue;
            end
        end
    end

`ifdef WB_INSTRET_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) instret <= 64'd0;
        else if (commit & ~ex_any) instret <= instret + 64'd1;
    end
`endif

endmodule
